// File: rtl/multi_alarm_clock.sv
// multi_alarm_clock: BCD 24h clock with N alarm slots,
// snooze, ring timeout and a gated square-wave tone.
module multi_alarm_clock #(
  parameter int CLK_HZ = 100_000_000,
  parameter int N_ALARMS = 4,
  parameter int SNOOZE_MIN = 5,
  parameter int RING_TIMEOUT_MIN = 10,
  parameter int TONE_DIV = 113_636,
  localparam int IW = $clog2(N_ALARMS)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          load,
  input  logic [3:0]    hourdec_init,
  input  logic [3:0]    hourone_init,
  input  logic [3:0]    mindec_init,
  input  logic [3:0]    minone_init,
  input  logic          bud_en,
  input  logic          alarm_wr,
  input  logic [IW-1:0] alarm_idx,
  input  logic          alarm_en_in,
  input  logic [3:0]    hourdec_bud,
  input  logic [3:0]    hourone_bud,
  input  logic [3:0]    mindec_bud,
  input  logic [3:0]    minone_bud,
  input  logic          off_bud,
  input  logic          snooze,
  output logic [3:0]    hourdec_now,
  output logic [3:0]    hourone_now,
  output logic [3:0]    mindec_now,
  output logic [3:0]    minone_now,
  output logic [5:0]    sec_now,
  output logic          sec_tick,
  output logic          ringing,
  output logic          snoozing,
  output logic [IW-1:0] ring_idx,
  output logic          aud_pwm
);

  localparam int PW = $clog2(CLK_HZ);
  localparam int TW = $clog2(TONE_DIV + 1);
  localparam logic [PW-1:0] P_MAX = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] P_HALF = PW'(CLK_HZ / 2);
  localparam logic [TW-1:0] T_MAX = TW'(TONE_DIV - 1);
  localparam logic [11:0] RING_LIM = 12'(RING_TIMEOUT_MIN * 60);
  localparam logic [11:0] SNZ_LEN = 12'(SNOOZE_MIN * 60);

  typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_e;

  function automatic logic bcd_ok(
    logic [3:0] a, logic [3:0] b,
    logic [3:0] c, logic [3:0] d);
    return a <= 4'd2 && b <= 4'd9 &&
           c <= 4'd5 && d <= 4'd9 &&
           !(a == 4'd2 && b > 4'd3);
  endfunction

  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    hd_q, hd_d, ho_q, ho_d;
  logic [3:0]    md_q, md_d, mo_q, mo_d;
  logic [5:0]    sec_q, sec_d;
  logic          tick_q, tick_d;
  logic          load_ok;

  assign load_ok = load && bcd_ok(hourdec_init,
    hourone_init, mindec_init, minone_init);

  always_comb begin
    presc_d = presc_q + 1'b1;
    hd_d = hd_q;
    ho_d = ho_q;
    md_d = md_q;
    mo_d = mo_q;
    sec_d = sec_q;
    tick_d = 1'b0;
    if (load_ok) begin
      presc_d = '0;
      hd_d = hourdec_init;
      ho_d = hourone_init;
      md_d = mindec_init;
      mo_d = minone_init;
      sec_d = '0;
    end else if (presc_q == P_MAX) begin
      presc_d = '0;
      tick_d = 1'b1;
      if (sec_q != 6'd59) sec_d = sec_q + 6'd1;
      else begin
        sec_d = '0;
        if (mo_q != 4'd9) mo_d = mo_q + 4'd1;
        else begin
          mo_d = '0;
          if (md_q != 4'd5) md_d = md_q + 4'd1;
          else begin
            md_d = '0;
            if (hd_q == 4'd2 && ho_q == 4'd3) begin
              hd_d = '0;
              ho_d = '0;
            end else if (ho_q == 4'd9) begin
              ho_d = '0;
              hd_d = hd_q + 4'd1;
            end else ho_d = ho_q + 4'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      presc_q <= '0;
      hd_q <= '0;
      ho_q <= '0;
      md_q <= '0;
      mo_q <= '0;
      sec_q <= '0;
      tick_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      hd_q <= hd_d;
      ho_q <= ho_d;
      md_q <= md_d;
      mo_q <= mo_d;
      sec_q <= sec_d;
      tick_q <= tick_d;
    end
  end

  logic        al_en_q [N_ALARMS];
  logic [15:0] al_t_q [N_ALARMS];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N_ALARMS; i++) begin
        al_en_q[i] <= 1'b0;
        al_t_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_ALARMS; i++)
        if (alarm_wr && alarm_idx == IW'(i)) begin
          al_en_q[i] <= alarm_en_in;
          al_t_q[i] <= {hourdec_bud, hourone_bud,
                        mindec_bud, minone_bud};
        end
    end
  end

  // Clock time is always valid BCD, so invalid slots never compare equal.
  logic          hit;
  logic [IW-1:0] hit_idx;

  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    for (int i = N_ALARMS - 1; i >= 0; i--)
      if (al_en_q[i] && al_t_q[i] == {hd_q, ho_q, md_q, mo_q}) begin
        hit = 1'b1;
        hit_idx = IW'(i);
      end
  end

  logic [2:0] off_s_q, snz_s_q;
  logic       off_e, snz_e;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      off_s_q <= '0;
      snz_s_q <= '0;
    end else begin
      off_s_q <= {off_s_q[1:0], off_bud};
      snz_s_q <= {snz_s_q[1:0], snooze};
    end
  end

  assign off_e = off_s_q[1] && !off_s_q[2];
  assign snz_e = snz_s_q[1] && !snz_s_q[2];

  state_e        state_q, state_d;
  logic [IW-1:0] ring_idx_q, ring_idx_d;
  logic [11:0]   ring_sec_q, ring_sec_d;
  logic [11:0]   snz_sec_q, snz_sec_d;
  logic          kill;

  assign kill = !bud_en || (alarm_wr && !alarm_en_in &&
                alarm_idx == ring_idx_q);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      ring_idx_q <= '0;
      ring_sec_q <= '0;
      snz_sec_q <= '0;
    end else begin
      state_q <= state_d;
      ring_idx_q <= ring_idx_d;
      ring_sec_q <= ring_sec_d;
      snz_sec_q <= snz_sec_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ring_idx_d = ring_idx_q;
    ring_sec_d = ring_sec_q;
    snz_sec_d = snz_sec_q;
    unique case (state_q)
      IDLE:
        if (tick_q && sec_q == '0 && bud_en && hit) begin
          state_d = RING;
          ring_idx_d = hit_idx;
          ring_sec_d = '0;
        end
      RING:
        if (kill || off_e) state_d = IDLE;
        else if (snz_e) begin
          state_d = SNOOZE;
          snz_sec_d = SNZ_LEN;
        end else if (tick_q) begin
          ring_sec_d = ring_sec_q + 12'd1;
          if (ring_sec_d == RING_LIM) state_d = IDLE;
        end
      SNOOZE:
        if (kill || off_e) state_d = IDLE;
        else if (tick_q) begin
          snz_sec_d = snz_sec_q - 12'd1;
          if (snz_sec_d == '0) begin
            state_d = RING;
            ring_sec_d = '0;
          end
        end
      default: state_d = IDLE;
    endcase
  end

  logic [TW-1:0] tone_cnt_q;
  logic          tone_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tone_cnt_q <= '0;
      tone_q <= 1'b0;
    end else if (state_q != RING) begin
      tone_cnt_q <= '0;
      tone_q <= 1'b0;
    end else if (tone_cnt_q == T_MAX) begin
      tone_cnt_q <= '0;
      tone_q <= !tone_q;
    end else tone_cnt_q <= tone_cnt_q + 1'b1;
  end

  always_comb begin
    ringing = state_q == RING;
    snoozing = state_q == SNOOZE;
    aud_pwm = ringing && tone_q && presc_q < P_HALF;
  end

  assign hourdec_now = hd_q;
  assign hourone_now = ho_q;
  assign mindec_now = md_q;
  assign minone_now = mo_q;
  assign sec_now = sec_q;
  assign sec_tick = tick_q;
  assign ring_idx = ring_idx_q;

endmodule

// File: tb/tb_multi_alarm_clock.sv
// tb_multi_alarm_clock: scenario tasks plus randomized runs
// checked against a seconds-of-day reference model.
module tb_multi_alarm_clock;
  localparam int CLK_HZ = 10;
  localparam int NA = 4;
  localparam int SNZ_MIN = 1;
  localparam int RTO_MIN = 2;
  localparam int TDIV = 2;
  localparam int T1150 = 11 * 3600 + 50 * 60;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic load = 1'b0;
  logic [3:0] hdi = '0, hoi = '0, mdi = '0, moi = '0;
  logic bud_en = 1'b0;
  logic alarm_wr = 1'b0;
  logic [1:0] alarm_idx = '0;
  logic alarm_en_in = 1'b0;
  logic [3:0] hdb = '0, hob = '0, mdb = '0, mob = '0;
  logic off_bud = 1'b0;
  logic snooze = 1'b0;
  logic [3:0] hdn, hon, mdn, mon;
  logic [5:0] secn;
  logic sec_tick, ringing, snoozing, aud_pwm;
  logic [1:0] ring_idx;

  int n_chk = 0;
  int n_pass = 0;
  int n_tick = 0;
  bit saw_ring = 1'b0;

  int m_presc, m_sod, m_st, m_idx;
  int m_rsec, m_snz, m_rcyc;
  bit m_tick;
  bit m_en [NA];
  int m_min [NA];
  bit off_h [3];
  bit snz_h [3];

  multi_alarm_clock #(
    .CLK_HZ(CLK_HZ), .N_ALARMS(NA),
    .SNOOZE_MIN(SNZ_MIN), .RING_TIMEOUT_MIN(RTO_MIN),
    .TONE_DIV(TDIV)
  ) dut (
    .clk(clk), .rstn(rstn), .load(load),
    .hourdec_init(hdi), .hourone_init(hoi),
    .mindec_init(mdi), .minone_init(moi),
    .bud_en(bud_en), .alarm_wr(alarm_wr),
    .alarm_idx(alarm_idx), .alarm_en_in(alarm_en_in),
    .hourdec_bud(hdb), .hourone_bud(hob),
    .mindec_bud(mdb), .minone_bud(mob),
    .off_bud(off_bud), .snooze(snooze),
    .hourdec_now(hdn), .hourone_now(hon),
    .mindec_now(mdn), .minone_now(mon),
    .sec_now(secn), .sec_tick(sec_tick),
    .ringing(ringing), .snoozing(snoozing),
    .ring_idx(ring_idx), .aud_pwm(aud_pwm)
  );

  always #5 clk = ~clk;

  function automatic int dut_sod();
    return (int'(hdn) * 10 + int'(hon)) * 3600 +
           (int'(mdn) * 10 + int'(mon)) * 60 + int'(secn);
  endfunction

  function automatic bit tb_ok(int a, int b, int c, int d);
    return a <= 2 && b <= 9 && c <= 5 && d <= 9 &&
           a * 10 + b <= 23;
  endfunction

  function automatic bit m_aud();
    return m_st == 1 && (m_rcyc / TDIV) % 2 == 1 &&
           m_presc < CLK_HZ / 2;
  endfunction

  task automatic model_reset();
    m_presc = 0; m_sod = 0; m_st = 0; m_idx = 0;
    m_rsec = 0; m_snz = 0; m_rcyc = 0; m_tick = 0;
    for (int i = 0; i < NA; i++) begin
      m_en[i] = 0;
      m_min[i] = 0;
    end
    for (int i = 0; i < 3; i++) begin
      off_h[i] = 0;
      snz_h[i] = 0;
    end
  endtask

  task automatic model_step();
    int np, ns, st, win;
    bit nt, off_e, snz_e, kill;
    off_e = off_h[1] && !off_h[2];
    snz_e = snz_h[1] && !snz_h[2];
    np = m_presc + 1;
    ns = m_sod;
    nt = 0;
    if (load && tb_ok(int'(hdi), int'(hoi), int'(mdi), int'(moi))) begin
      ns = (int'(hdi) * 10 + int'(hoi)) * 3600 +
           (int'(mdi) * 10 + int'(moi)) * 60;
      np = 0;
    end else if (m_presc == CLK_HZ - 1) begin
      np = 0;
      ns = (m_sod + 1) % 86400;
      nt = 1;
    end
    win = -1;
    if (m_tick && m_sod % 60 == 0 && bud_en && m_st == 0)
      for (int i = 0; i < NA; i++)
        if (win < 0 && m_en[i] && m_min[i] == m_sod / 60) win = i;
    kill = !bud_en ||
           (alarm_wr && !alarm_en_in && int'(alarm_idx) == m_idx);
    st = m_st;
    if (m_st == 0) begin
      if (win >= 0) begin
        st = 1; m_idx = win; m_rsec = 0;
      end
    end else if (kill || off_e) st = 0;
    else if (m_st == 1) begin
      if (snz_e) begin
        st = 2; m_snz = SNZ_MIN * 60;
      end else if (m_tick) begin
        m_rsec++;
        if (m_rsec >= RTO_MIN * 60) st = 0;
      end
    end else if (m_tick) begin
      m_snz--;
      if (m_snz == 0) begin
        st = 1; m_rsec = 0;
      end
    end
    m_rcyc = (st == 1 && m_st == 1) ? m_rcyc + 1 : 0;
    if (alarm_wr) begin
      m_en[alarm_idx] = alarm_en_in;
      m_min[alarm_idx] =
        tb_ok(int'(hdb), int'(hob), int'(mdb), int'(mob)) ?
        (int'(hdb) * 10 + int'(hob)) * 60 +
        int'(mdb) * 10 + int'(mob) : -1;
    end
    off_h[2] = off_h[1]; off_h[1] = off_h[0]; off_h[0] = off_bud;
    snz_h[2] = snz_h[1]; snz_h[1] = snz_h[0]; snz_h[0] = snooze;
    m_presc = np; m_sod = ns; m_tick = nt; m_st = st;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (sec_tick) n_tick++;
    if (ringing) saw_ring = 1;
  endtask

  task automatic load_raw(input int a, input int b,
                          input int c, input int d);
    hdi = 4'(a); hoi = 4'(b); mdi = 4'(c); moi = 4'(d);
    load = 1; cyc(); load = 0;
  endtask

  task automatic set_load(input int h, input int m);
    load_raw(h / 10, h % 10, m / 10, m % 10);
  endtask

  task automatic set_alarm(input int idx, input bit en,
                           input int h, input int m);
    alarm_idx = 2'(idx); alarm_en_in = en;
    hdb = 4'(h / 10); hob = 4'(h % 10);
    mdb = 4'(m / 10); mob = 4'(m % 10);
    alarm_wr = 1; cyc(); alarm_wr = 0;
  endtask

  task automatic wait_ring();
    for (int i = 0; i < 700 && !ringing; i++) cyc();
  endtask

  task automatic test_reset();
    rstn = 0;
    model_reset();
    repeat (3) @(negedge clk);
    n_chk++;
    if (dut_sod() !== 0) $display("FAIL reset_time: got %0d want 0", dut_sod());
    else n_pass++;
    n_chk++;
    if ({sec_tick, ringing, snoozing, aud_pwm, ring_idx} !== 6'b0)
      $display("FAIL reset_outs: got %b want 0",
        {sec_tick, ringing, snoozing, aud_pwm, ring_idx});
    else n_pass++;
    rstn = 1;
    bud_en = 1;
  endtask

  task automatic test_rollover();
    set_load(23, 59);
    n_tick = 0; saw_ring = 0;
    repeat (600) cyc();
    n_chk++;
    if (dut_sod() !== 0) $display("FAIL rollover_time: got %0d want 0", dut_sod());
    else n_pass++;
    n_chk++;
    if (n_tick !== 60) $display("FAIL rollover_ticks: got %0d want 60", n_tick);
    else n_pass++;
    n_chk++;
    if (saw_ring !== 0) $display("FAIL rollover_ring: got %0d want 0", saw_ring);
    else n_pass++;
  endtask

  task automatic test_match();
    set_alarm(0, 1, $urandom_range(0, 9), $urandom_range(0, 59));
    set_alarm(1, 1, 11, 50);
    set_alarm(2, 0, 11, 50);
    set_alarm(3, 1, 11, 50);
    set_load(11, 49);
    for (int i = 0; i < 700 && dut_sod() != T1150; i++) cyc();
    n_chk++;
    if (sec_tick !== 1 || ringing !== 0)
      $display("FAIL match_pre: got tick=%0d ring=%0d want 1 0", sec_tick, ringing);
    else n_pass++;
    cyc();
    n_chk++;
    if (ringing !== 1) $display("FAIL match_ring: got %0d want 1", ringing);
    else n_pass++;
    n_chk++;
    if (ring_idx !== 2'd1) $display("FAIL match_idx: got %0d want 1", ring_idx);
    else n_pass++;
    for (int i = 0; i < 12; i++) begin
      cyc();
      n_chk++;
      if (aud_pwm !== m_aud())
        $display("FAIL tone: cyc %0d got %0d want %0d", i, aud_pwm, m_aud());
      else n_pass++;
    end
  endtask

  task automatic test_stop();
    repeat ($urandom_range(0, 20)) cyc();
    off_bud = 1;
    cyc();
    cyc();
    n_chk++;
    if (ringing !== 1) $display("FAIL stop_early: got %0d want 1", ringing);
    else n_pass++;
    cyc();
    off_bud = 0;
    n_chk++;
    if (ringing !== 0) $display("FAIL stop: got %0d want 0", ringing);
    else n_pass++;
    saw_ring = 0;
    repeat (600) cyc();
    n_chk++;
    if (saw_ring !== 0) $display("FAIL stop_rering: got %0d want 0", saw_ring);
    else n_pass++;
  endtask

  task automatic test_snooze();
    set_load(11, 49);
    wait_ring();
    n_chk++;
    if (ringing !== 1) $display("FAIL snz_ring: got %0d want 1", ringing);
    else n_pass++;
    repeat ($urandom_range(0, 30)) cyc();
    snooze = 1;
    cyc();
    cyc();
    snooze = 0;
    cyc();
    n_chk++;
    if (snoozing !== 1 || ringing !== 0)
      $display("FAIL snz_enter: got snz=%0d ring=%0d want 1 0", snoozing, ringing);
    else n_pass++;
    n_tick = int'(sec_tick);
    for (int i = 0; i < 700 && !ringing; i++) cyc();
    n_chk++;
    if (n_tick !== SNZ_MIN * 60 || ringing !== 1)
      $display("FAIL snz_len: got %0d ticks ring=%0d want %0d 1",
        n_tick, ringing, SNZ_MIN * 60);
    else n_pass++;
    n_chk++;
    if (ring_idx !== 2'd1) $display("FAIL snz_idx: got %0d want 1", ring_idx);
    else n_pass++;
    off_bud = 1;
    cyc();
    cyc();
    off_bud = 0;
    cyc();
    n_chk++;
    if (ringing !== 0 || snoozing !== 0)
      $display("FAIL snz_off: got ring=%0d snz=%0d want 0 0", ringing, snoozing);
    else n_pass++;
  endtask

  task automatic test_timeout();
    set_load(11, 49);
    wait_ring();
    n_tick = 0;
    for (int i = 0; i < 1400 && ringing; i++) cyc();
    n_chk++;
    if (n_tick !== RTO_MIN * 60 || ringing !== 0)
      $display("FAIL timeout: got %0d ticks ring=%0d want %0d 0",
        n_tick, ringing, RTO_MIN * 60);
    else n_pass++;
  endtask

  task automatic test_kill();
    set_load(11, 49);
    wait_ring();
    repeat ($urandom_range(0, 20)) cyc();
    bud_en = 0;
    cyc();
    bud_en = 1;
    n_chk++;
    if (ringing !== 0) $display("FAIL kill_buden: got %0d want 0", ringing);
    else n_pass++;
    set_load(11, 49);
    wait_ring();
    set_alarm(1, 0, 11, 50);
    n_chk++;
    if (ringing !== 0) $display("FAIL kill_wr: got %0d want 0", ringing);
    else n_pass++;
    set_load(11, 49);
    for (int i = 0; i < 700 && dut_sod() != T1150; i++) cyc();
    set_alarm(3, 0, 11, 50);
    n_chk++;
    if (ringing !== 1 || ring_idx !== 2'd3)
      $display("FAIL wr_race: got ring=%0d idx=%0d want 1 3", ringing, ring_idx);
    else n_pass++;
    off_bud = 1;
    repeat (3) cyc();
    off_bud = 0;
    n_chk++;
    if (ringing !== 0) $display("FAIL race_off: got %0d want 0", ringing);
    else n_pass++;
  endtask

  task automatic test_invalid_load();
    int a, b, c, d;
    load_raw(2, 4, 0, 0);
    n_chk++;
    if (dut_sod() !== m_sod || hdn * 10 + hon == 24)
      $display("FAIL load_2400: got %0d want %0d", dut_sod(), m_sod);
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      do begin
        a = $urandom_range(0, 15); b = $urandom_range(0, 15);
        c = $urandom_range(0, 15); d = $urandom_range(0, 15);
      end while (tb_ok(a, b, c, d));
      load_raw(a, b, c, d);
      n_chk++;
      if (dut_sod() !== m_sod)
        $display("FAIL load_bad %0d%0d:%0d%0d: got %0d want %0d",
          a, b, c, d, dut_sod(), m_sod);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int slot, hh, mm, act, at, len;
    for (int it = 0; it < 3; it++) begin
      for (int s = 0; s < NA; s++) set_alarm(s, 0, 0, 0);
      slot = $urandom_range(0, NA - 1);
      hh = $urandom_range(0, 23);
      mm = $urandom_range(1, 59);
      set_alarm(slot, 1, hh, mm);
      if ($urandom_range(0, 1) == 1)
        set_alarm($urandom_range(0, NA - 1), 1, hh, mm);
      set_load(hh, mm - 1);
      act = $urandom_range(0, 3);
      at = $urandom_range(600, 700);
      len = $urandom_range(1, 3);
      for (int c = 0; c < 1500; c++) begin
        off_bud = (act == 1 && c >= at && c < at + len) ||
                  (act == 2 && c >= at + 300 && c < at + 300 + len);
        snooze = act == 2 && c >= at && c < at + len;
        bud_en = !(act == 3 && c >= at && c < at + len);
        cyc();
        n_chk++;
        if (dut_sod() !== m_sod || sec_tick !== m_tick) begin
          if (n_chk - n_pass < 20)
            $display("FAIL rnd_time: got %0d/%0d want %0d/%0d",
              dut_sod(), sec_tick, m_sod, m_tick);
        end else n_pass++;
        n_chk++;
        if (ringing !== (m_st == 1) || snoozing !== (m_st == 2)) begin
          if (n_chk - n_pass < 20)
            $display("FAIL rnd_state: got r%0d s%0d want state %0d",
              ringing, snoozing, m_st);
        end else n_pass++;
        n_chk++;
        if (int'(ring_idx) !== m_idx || aud_pwm !== m_aud()) begin
          if (n_chk - n_pass < 20)
            $display("FAIL rnd_idx_aud: got %0d/%0d want %0d/%0d",
              ring_idx, aud_pwm, m_idx, m_aud());
        end else n_pass++;
      end
    end
    off_bud = 0; snooze = 0; bud_en = 1;
  endtask

  task automatic test_reset_ring();
    bud_en = 0;
    cyc();
    bud_en = 1;
    set_alarm(1, 1, 11, 50);
    set_load(11, 49);
    wait_ring();
    n_chk++;
    if (ringing !== 1) $display("FAIL rst_pre: got %0d want 1", ringing);
    else n_pass++;
    rstn = 0;
    #1;
    n_chk++;
    if ({sec_tick, ringing, snoozing, aud_pwm, ring_idx} !== 6'b0 ||
        dut_sod() !== 0)
      $display("FAIL rst_async: got %b t%0d want 0",
        {sec_tick, ringing, snoozing, aud_pwm, ring_idx}, dut_sod());
    else n_pass++;
    model_reset();
    @(negedge clk);
    rstn = 1;
    set_load(11, 49);
    saw_ring = 0;
    repeat (650) cyc();
    n_chk++;
    if (saw_ring !== 0) $display("FAIL rst_table: got %0d want 0", saw_ring);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_rollover();
    test_match();
    test_stop();
    test_snooze();
    test_timeout();
    test_kill();
    test_invalid_load();
    test_random();
    test_reset_ring();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/multi_alarm_clock.md
# multi_alarm_clock

Parametrised successor to the single-alarm watch core: a BCD 24-hour clock with N independently programmable alarms, snooze, ring timeout and a gated square-wave tone output. It sits between the board top level (buttons, LEDs, audio PWM pin) and the time/alarm registers. It adds a runtime-writable alarm table and a ringing state machine, which the single-alarm core does not have.

## Interface
- CLK_HZ, 100_000_000: clk cycles per second; ≥ 4, even.
- N_ALARMS, 4: number of alarm slots; 2..16.
- SNOOZE_MIN, 5: snooze length in minutes; 1..59.
- RING_TIMEOUT_MIN, 10: auto-stop after this many minutes of continuous ringing; 1..59.
- TONE_DIV, 113_636: clk cycles per tone half-period (440 Hz at 100 MHz); ≥ 1.

Ports (IW = $clog2(N_ALARMS)):
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- load  in  1  pulse; loads the *_init time.
- hourdec_init, hourone_init, mindec_init, minone_init  in  4 each  BCD time to load.
- bud_en  in  1  global alarm enable.
- alarm_wr  in  1  pulse; writes one alarm slot.
- alarm_idx  in  IW  slot to write.
- alarm_en_in  in  1  enable bit for the slot.
- hourdec_bud, hourone_bud, mindec_bud, minone_bud  in  4 each  BCD alarm time for the slot.
- off_bud  in  1  stop button; asynchronous, level.
- snooze  in  1  snooze button; asynchronous, level.
- hourdec_now, hourone_now, mindec_now, minone_now  out  4 each  current BCD time.
- sec_now  out  6  binary seconds 0..59.
- sec_tick  out  1  one-cycle pulse when time advances.
- ringing  out  1  high in RING.
- snoozing  out  1  high in SNOOZE.
- ring_idx  out  IW  slot that caused the current ring.
- aud_pwm  out  1  tone output.

## Operation
- Prescaler counts 0..CLK_HZ-1. When it equals CLK_HZ-1, the time advances by one second. Seconds, minutes and hours carry BCD-correctly. 23:59:59 wraps to 00:00:00.
- Load:
  - Load has priority over a tick.
  - A load sets the time to the init value, with sec = 0 and prescaler = 0.
  - A load is ignored if the init value is invalid BCD: hourdec > 2, hour > 23, mindec > 5, or any digit > 9.
  - A load never triggers an alarm match.
- Alarm table: per slot, an en bit plus hh:mm.
  - alarm_wr writes the addressed slot.
  - alarm_idx ≥ N_ALARMS is ignored.
  - Invalid BCD is stored but can never match.
- Match condition: a tick produces sec = 0, hh:mm equals an enabled slot, bud_en = 1, and the state is IDLE. The lowest matching index wins.
- Matches occurring in RING or SNOOZE are discarded.
- off_bud and snooze each pass through a 2-flop synchronizer and a rising-edge detector. Only edges act.
- FSM states: IDLE, RING, SNOOZE.
  - IDLE → RING on a match. ring_idx := the winning index; ring_sec := 0.
  - RING → IDLE on an off_bud edge.
  - RING → IDLE when ring_sec reaches RING_TIMEOUT_MIN*60 (ring_sec increments on each tick).
  - RING → SNOOZE on a snooze edge. snz_sec := SNOOZE_MIN*60.
  - SNOOZE decrements snz_sec on each tick. SNOOZE → RING when snz_sec reaches 0; ring_sec := 0.
  - SNOOZE → IDLE on an off_bud edge.
  - Simultaneous off_bud and snooze edges: off_bud wins.
- bud_en = 0, or an alarm_wr that clears en of slot ring_idx, forces IDLE from RING or SNOOZE on the next edge.
- Tone:
  - The tone counter toggles a tone bit every TONE_DIV cycles and runs only in RING. It is cleared outside RING.
  - aud_pwm = tone bit AND (prescaler < CLK_HZ/2). This gives a 0.5 s on / 0.5 s off beep. Outside RING, aud_pwm = 0.
- Reset values:
  - Time 00:00:00; prescaler 0.
  - All alarm slots en = 0, time 00:00.
  - State IDLE; ring_idx 0; counters 0.
  - Synchronizers 0.
  - All outputs 0.

## Timing
- All outputs are registered.
- sec_tick is high in the cycle after prescaler = CLK_HZ-1, the same cycle the new time is visible.
- Load: the new time is visible on the cycle after load is sampled.
- Match is evaluated registered. ringing and ring_idx rise one cycle after the time shows hh:mm:00.
- Button latency: with off_bud first sampled high at edge k, the state changes at edge k+2 and ringing is low after edge k+2.
- alarm_wr takes effect one cycle later. A write and a match in the same cycle: the match uses the old slot contents.

## Test plan
Sim parameters: CLK_HZ = 10, N_ALARMS = 4, SNOOZE_MIN = 1, RING_TIMEOUT_MIN = 2, TONE_DIV = 2.
- Rollover: load 23:59, run 600 cycles → time reads 00:00:00; sec_tick pulsed exactly 60 times; ringing stays 0.
- Match priority: slots 1 and 3 both enabled at 11:50, load 11:49, run to 11:50:00 → ringing = 1 one cycle later, ring_idx = 1; aud_pwm toggles every 2 cycles during prescaler 0..4 and is 0 during 5..9.
- Stop: while ringing, pulse off_bud 3 cycles → IDLE 2 edges after the first sample; reaching 11:50:00 again within the same day does not re-ring before 24 h.
- Snooze: ring at 11:50, snooze edge → snoozing = 1; after 60 ticks → ringing = 1; then off_bud → IDLE.
- Timeout, bud_en and invalid load:
  - No buttons → ringing clears after 120 ticks.
  - Repeat with bud_en dropped mid-ring → IDLE next edge.
  - Load 24:00 → ignored.
- Async reset mid-RING: assert rstn low → all outputs 0 immediately; alarm table cleared, so no re-ring at 11:50.
